hazard_ctrl: RTL and testbench

Central hazard controller for the 5-stage RV32I pipeline. It produces forwarding selects for EX, and stall/flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers. It sequences the data-memory access held in the MEM stage through a req/ready handshake with a timeout watchdog. It sits beside the datapath and owns every stage enable and clear.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_ctrl_if.sv | 53 +++++
 rtl/forward_unit.sv | 30 +++
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the RV32I pipeline hazard controller.
//   fwd_sel_e   : EX operand forward select (regfile / WB result / MEM ALU result)
//   hz_state_e  : MEM-stage access sequencer states
//   REG_ZERO    : x0, never a forwarding or load-use source
//   WIDTH       : datapath width, kept so the whole pipeline shares one constant
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int WIDTH = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle of every signal exchanged between the hazard controller and the
// pipeline datapath / data memory.
//   master : the hazard controller (drives stage controls, forwards, mem_req_o)
//   slave  : the datapath side (drives register fields, stage control bits,
//            mem_ready_i)
// Build option: HAZARD_PERF_EN adds the three performance counter outputs.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;

  logic [4:0] Rs1_D, Rs2_D;
  logic [4:0] Rs1_E, Rs2_E, Rd_E;
  logic       MemRead_E;
  logic       PCSrc_E;
  logic [4:0] Rd_M;
  logic       RegWrite_M, MemRead_M, MemWrite_M;
  logic [4:0] Rd_W;
  logic       RegWrite_W;
  logic       mem_ready_i;

  logic       mem_req_o;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic       Stall_F, Stall_D, Stall_E, Stall_M;
  logic       Flush_D, Flush_E;
  logic       mem_err_o;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_memstall_o, perf_loaduse_o, perf_flush_o;
`endif

  modport master (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, MemRead_E, PCSrc_E,
           Rd_M, RegWrite_M, MemRead_M, MemWrite_M, Rd_W, RegWrite_W,
           mem_ready_i,
    output mem_req_o, ForwardA_E, ForwardB_E,
           Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, mem_err_o
`ifdef HAZARD_PERF_EN
    , output perf_memstall_o, perf_loaduse_o, perf_flush_o
`endif
  );

  modport slave (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, MemRead_E, PCSrc_E,
           Rd_M, RegWrite_M, MemRead_M, MemWrite_M, Rd_W, RegWrite_W,
           mem_ready_i,
    input  mem_req_o, ForwardA_E, ForwardB_E,
           Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, mem_err_o
`ifdef HAZARD_PERF_EN
    , input perf_memstall_o, perf_loaduse_o, perf_flush_o
`endif
  );

endinterface

// File: rtl/forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
// Combinational forward select for one EX source operand. The MEM-stage
// producer is younger than the WB-stage one, so it takes priority.
//   rs_e              : source register of the operand in EX
//   rd_m, reg_write_m : MEM-stage destination and write enable
//   rd_w, reg_write_w : WB-stage destination and write enable
//   fwd               : FWD_M / FWD_W / FWD_RF
// -----------------------------------------------------------------------------
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output fwd_sel_e   fwd
);

  always_comb begin
    if (reg_write_m && rd_m != REG_ZERO && rd_m == rs_e)
      fwd = FWD_M;
    else if (reg_write_w && rd_w != REG_ZERO && rd_w == rs_e)
      fwd = FWD_W;
    else
      fwd = FWD_RF;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Central hazard controller for the 5-stage RV32I pipeline: EX forwarding,
// stage stall/flush, and sequencing of the MEM-stage data access through a
// req/ready handshake guarded by a timeout watchdog.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   hif        : hazard_ctrl_if.master (all pipeline/memory signals)
// Parameters:
//   MEM_TIMEOUT : MEM_WAIT cycles without ready before mem_err_o is raised
//   TO_W        : timeout counter width, >= clog2(MEM_TIMEOUT+1)
// Build option: HAZARD_PERF_EN adds stall/load-use/flush cycle counters.
// All stage controls are combinational from inputs and state; only the FSM,
// the timeout count and mem_err_o (and the optional counters) are registered.
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 7
) (
  input logic        clk,
  input logic        rst_n,
  hazard_ctrl_if.master hif
);

  hz_state_e         state_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              mem_err_q;

  fwd_sel_e fwd_a, fwd_b;

  forward_unit u_fwd_a (
    .rs_e        (hif.Rs1_E),
    .rd_m        (hif.Rd_M),
    .reg_write_m (hif.RegWrite_M),
    .rd_w        (hif.Rd_W),
    .reg_write_w (hif.RegWrite_W),
    .fwd         (fwd_a)
  );

  forward_unit u_fwd_b (
    .rs_e        (hif.Rs2_E),
    .rd_m        (hif.Rd_M),
    .reg_write_m (hif.RegWrite_M),
    .rd_w        (hif.Rd_W),
    .reg_write_w (hif.RegWrite_W),
    .fwd         (fwd_b)
  );

  logic mem_access, mem_stall, load_use, branch;

  assign mem_access = hif.MemRead_M | hif.MemWrite_M;
  assign mem_stall  = ((state_q == RUN) && mem_access && !hif.mem_ready_i) ||
                      ((state_q == MEM_WAIT) && !hif.mem_ready_i);
  assign load_use   = hif.MemRead_E && (hif.Rd_E != REG_ZERO) &&
                      ((hif.Rd_E == hif.Rs1_D) || (hif.Rd_E == hif.Rs2_D));
  assign branch     = hif.PCSrc_E;

  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, req;

  // Priority: ERR > mem_stall > branch > load-use. Everything is forced low
  // while rst_n is asserted, independent of the clock.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    req     = 1'b0;
    if (rst_n) begin
      if (state_q == ERR) begin
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
      end else begin
        req = mem_access;
        if (mem_stall) begin
          // The branch in EX is frozen with the rest of the pipe and is acted
          // on once memory releases the stall.
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        end else if (branch) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
    end
  end

  assign hif.Stall_F    = stall_f;
  assign hif.Stall_D    = stall_d;
  assign hif.Stall_E    = stall_e;
  assign hif.Stall_M    = stall_m;
  assign hif.Flush_D    = flush_d;
  assign hif.Flush_E    = flush_e;
  assign hif.mem_req_o  = req;
  assign hif.ForwardA_E = rst_n ? fwd_a : FWD_RF;
  assign hif.ForwardB_E = rst_n ? fwd_b : FWD_RF;
  assign hif.mem_err_o  = mem_err_q;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      to_cnt_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_access && !hif.mem_ready_i) begin
            state_q  <= MEM_WAIT;
            to_cnt_q <= '0;
          end
        end
        MEM_WAIT: begin
          if (hif.mem_ready_i) begin
            state_q  <= RUN;
            to_cnt_q <= '0;
          end else if (to_cnt_q == TO_LAST) begin
            state_q   <= ERR;
            to_cnt_q  <= '0;
            mem_err_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        ERR: ;  // absorbing until reset
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_memstall_q, perf_loaduse_q, perf_flush_q;

  // Counters follow the effective (priority-resolved) controls and stop in ERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_memstall_q <= '0;
      perf_loaduse_q  <= '0;
      perf_flush_q    <= '0;
    end else if (state_q != ERR) begin
      if (mem_stall)                        perf_memstall_q <= perf_memstall_q + 1'b1;
      if (!mem_stall && !branch && load_use) perf_loaduse_q <= perf_loaduse_q + 1'b1;
      if (!mem_stall && branch)             perf_flush_q    <= perf_flush_q + 1'b1;
    end
  end

  assign hif.perf_memstall_o = perf_memstall_q;
  assign hif.perf_loaduse_o  = perf_loaduse_q;
  assign hif.perf_flush_o    = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl: a table of single-cycle vectors for
// forwarding / load-use / branch in RUN, followed by hand-written sequences
// for reset, memory wait with a pending branch, timeout into ERR, and an
// asynchronous reset in the middle of MEM_WAIT.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.MEM_TIMEOUT(64), .TO_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {Stall_F,Stall_D,Stall_E,Stall_M,Flush_D,Flush_E,mem_req_o}
  function automatic logic [6:0] ctl_vec();
    return {hif.Stall_F, hif.Stall_D, hif.Stall_E, hif.Stall_M,
            hif.Flush_D, hif.Flush_E, hif.mem_req_o};
  endfunction

  typedef struct {
    string      name;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic       memread_e, pcsrc_e;
    logic [4:0] rd_m;
    logic       regwrite_m;
    logic [4:0] rd_w;
    logic       regwrite_w;
    logic [1:0] exp_fa, exp_fb;
    logic [6:0] exp_ctl;
  } vec_t;

  vec_t vecs[10];

  task automatic clear_inputs();
    hif.Rs1_D = 0; hif.Rs2_D = 0; hif.Rs1_E = 0; hif.Rs2_E = 0; hif.Rd_E = 0;
    hif.MemRead_E = 0; hif.PCSrc_E = 0; hif.Rd_M = 0; hif.RegWrite_M = 0;
    hif.MemRead_M = 0; hif.MemWrite_M = 0; hif.Rd_W = 0; hif.RegWrite_W = 0;
    hif.mem_ready_i = 0;
  endtask

  // Drive right after the rising edge, sample at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            name        rs1d rs2d rs1e rs2e rde mre pcs rdm rwm rdw rww  fa     fb     ctl
    vecs[0] = '{"fwd_m_pri",  0,   0,   5,   0,   0,  0,  0,  5,  1,  5,  1,  2'b10, 2'b00, 7'b0};
    vecs[1] = '{"fwd_w_rdm0", 0,   0,   5,   0,   0,  0,  0,  0,  1,  5,  1,  2'b01, 2'b00, 7'b0};
    vecs[2] = '{"fwd_w_nowm", 0,   0,   5,   0,   0,  0,  0,  5,  0,  5,  1,  2'b01, 2'b00, 7'b0};
    vecs[3] = '{"fwd_b_m",    0,   0,   3,   9,   0,  0,  0,  9,  1,  3,  1,  2'b01, 2'b10, 7'b0};
    vecs[4] = '{"fwd_x0",     0,   0,   0,   0,   0,  0,  0,  0,  1,  0,  1,  2'b00, 2'b00, 7'b0};
    vecs[5] = '{"loaduse_rs2",1,   7,   0,   0,   7,  1,  0,  0,  0,  0,  0,  2'b00, 2'b00, 7'b1100010};
    vecs[6] = '{"loaduse_x0", 0,   4,   0,   0,   0,  1,  0,  0,  0,  0,  0,  2'b00, 2'b00, 7'b0};
    vecs[7] = '{"no_load",    7,   0,   0,   0,   7,  0,  0,  0,  0,  0,  0,  2'b00, 2'b00, 7'b0};
    vecs[8] = '{"branch",     0,   0,   0,   0,   0,  0,  1,  0,  0,  0,  0,  2'b00, 2'b00, 7'b0000110};
    vecs[9] = '{"br_over_lu", 7,   0,   0,   0,   7,  1,  1,  0,  0,  0,  0,  2'b00, 2'b00, 7'b0000110};

    // ---- reset: outputs forced to 0 even with live hazards on the inputs
    clear_inputs();
    hif.MemRead_M = 1; hif.PCSrc_E = 1; hif.Rs1_E = 5; hif.Rd_M = 5; hif.RegWrite_M = 1;
    #1;
    check("rst_ctl", 32'(ctl_vec()), 32'd0);
    check("rst_fwd_a", 32'(hif.ForwardA_E), 32'd0);
    check("rst_err", 32'(hif.mem_err_o), 32'd0);
    clear_inputs();
    #12 rst_n = 1'b1;
    next_cycle();

    // ---- table vectors in RUN (no memory access)
    for (int i = 0; i < 10; i++) begin
      clear_inputs();
      hif.Rs1_D = vecs[i].rs1_d; hif.Rs2_D = vecs[i].rs2_d;
      hif.Rs1_E = vecs[i].rs1_e; hif.Rs2_E = vecs[i].rs2_e; hif.Rd_E = vecs[i].rd_e;
      hif.MemRead_E = vecs[i].memread_e; hif.PCSrc_E = vecs[i].pcsrc_e;
      hif.Rd_M = vecs[i].rd_m; hif.RegWrite_M = vecs[i].regwrite_m;
      hif.Rd_W = vecs[i].rd_w; hif.RegWrite_W = vecs[i].regwrite_w;
      @(negedge clk);
      check({vecs[i].name, "_fa"}, 32'(hif.ForwardA_E), 32'(vecs[i].exp_fa));
      check({vecs[i].name, "_fb"}, 32'(hif.ForwardB_E), 32'(vecs[i].exp_fb));
      check({vecs[i].name, "_ctl"}, 32'(ctl_vec()), 32'(vecs[i].exp_ctl));
      next_cycle();
    end

    // ---- load-use bubble: the flushed ID/EX slot carries no load next cycle
    clear_inputs();
    hif.MemRead_E = 1; hif.Rd_E = 7; hif.Rs2_D = 7;
    @(negedge clk);
    check("lu_seq_stall", 32'(ctl_vec()), 32'b1100010);
    next_cycle();
    hif.MemRead_E = 0; hif.Rd_E = 0;
    @(negedge clk);
    check("lu_seq_release", 32'(ctl_vec()), 32'd0);
    next_cycle();

    // ---- memory wait 3 cycles with a branch pending in EX
    clear_inputs();
    hif.MemRead_M = 1; hif.PCSrc_E = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("memwait_c%0d", c), 32'(ctl_vec()), 32'b1111001);
      next_cycle();
    end
    hif.mem_ready_i = 1;
    @(negedge clk);
    check("memwait_ready", 32'(ctl_vec()), 32'b0000111);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("memwait_back_run", 32'(ctl_vec()), 32'd0);
    next_cycle();

    // ---- timeout: cycle 0 in RUN, then 64 MEM_WAIT cycles, then ERR
    clear_inputs();
    hif.MemWrite_M = 1;
    for (int c = 0; c < 65; c++) begin
      @(negedge clk);
      check($sformatf("to_wait_c%0d", c), 32'({ctl_vec(), hif.mem_err_o}), 32'b11110010);
      next_cycle();
    end
    hif.PCSrc_E = 1;
    @(negedge clk);
    check("err_set", 32'(hif.mem_err_o), 32'd1);
    check("err_ctl", 32'(ctl_vec()), 32'b1111000);
    next_cycle();
    hif.mem_ready_i = 1;
    @(negedge clk);
    check("err_absorb", 32'({ctl_vec(), hif.mem_err_o}), 32'b11110001);
    #1 rst_n = 1'b0;
    #1;
    check("err_rst_ctl", 32'({ctl_vec(), hif.mem_err_o}), 32'd0);
    clear_inputs();
    #1 rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("err_rst_run", 32'({ctl_vec(), hif.mem_err_o}), 32'd0);
    next_cycle();

    // ---- asynchronous reset in the middle of MEM_WAIT
    clear_inputs();
    hif.MemRead_M = 1; hif.Rs1_E = 6; hif.Rd_W = 6; hif.RegWrite_W = 1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("mid_wait_stall", 32'(ctl_vec()), 32'b1111001);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", 32'(ctl_vec()), 32'd0);
    check("mid_rst_fwd", 32'(hif.ForwardA_E), 32'd0);
    // ready stays low with no access: MEM_WAIT would stall, RUN does not
    hif.MemRead_M = 0;
    #1 rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("mid_rst_run", 32'(ctl_vec()), 32'd0);
    check("mid_rst_fwd_w", 32'(hif.ForwardA_E), 32'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
